// File: rtl/mu0_control.sv
// MU0 fetch/execute controller: decodes state and opcode into datapath selects and enables,
// stalls on the memory handshake, and halts with Err if the bus stays not-ready too long.
module mu0_control #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       MemRdy,
    output logic       Asel,
    output logic       Xsel,
    output logic       Ysel,
    output logic [1:0] ALUfs,
    output logic       ACCce,
    output logic       PCce,
    output logic       IRce,
    output logic       ACCoe,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Halted,
    output logic       Err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stall;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (stall) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // This stall cycle is the last one tolerated: abandon the access.
            if (cnt_q >= WAIT_LAST) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
        end else begin
            cnt_d = '0;
            case (state_q)
                S_FETCH: state_d = S_EXEC;
                S_EXEC:  state_d = (F == 4'd7) ? S_HALT : S_FETCH;
                default: state_d = S_HALT;
            endcase
        end
    end

    always_comb begin
        Asel   = 1'b0;
        Xsel   = 1'b0;
        Ysel   = 1'b0;
        ALUfs  = 2'b00;
        ACCce  = 1'b0;
        PCce   = 1'b0;
        IRce   = 1'b0;
        ACCoe  = 1'b0;
        MEMrq  = 1'b0;
        RnW    = 1'b1;
        Halted = 1'b0;
        stall  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MEMrq = 1'b1;
                IRce  = 1'b1;
                Xsel  = 1'b1;
                ALUfs = 2'b10;
                PCce  = 1'b1;
            end
            S_EXEC: begin
                case (F)
                    4'd0: begin
                        Asel  = 1'b1;
                        MEMrq = 1'b1;
                        ACCce = 1'b1;
                    end
                    4'd1: begin
                        Asel  = 1'b1;
                        MEMrq = 1'b1;
                        RnW   = 1'b0;
                        ACCoe = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        Asel  = 1'b1;
                        MEMrq = 1'b1;
                        ALUfs = (F == 4'd2) ? 2'b01 : 2'b11;
                        ACCce = 1'b1;
                    end
                    4'd4: begin
                        Ysel = 1'b1;
                        PCce = 1'b1;
                    end
                    4'd5: begin
                        Ysel = 1'b1;
                        PCce = ~N;
                    end
                    4'd6: begin
                        Ysel = 1'b1;
                        PCce = ~Z;
                    end
                    default: ;
                endcase
            end
            default: Halted = 1'b1;
        endcase

        // Not-ready memory: hold the request stable but suppress every register update.
        stall = MEMrq & ~MemRdy;
        if (stall) begin
            ACCce = 1'b0;
            PCce  = 1'b0;
            IRce  = 1'b0;
        end

        if (!nReset) begin
            Asel   = 1'b0;
            Xsel   = 1'b0;
            Ysel   = 1'b0;
            ALUfs  = 2'b00;
            ACCce  = 1'b0;
            PCce   = 1'b0;
            IRce   = 1'b0;
            ACCoe  = 1'b0;
            MEMrq  = 1'b0;
            RnW    = 1'b1;
            Halted = 1'b0;
            stall  = 1'b0;
        end
    end

    assign Err = err_q;

endmodule
